bam_seq_mul_ctrl: RTL and testbench

- Sequential, runtime-configurable broken-array multiplier (BAM) for the approximate-arithmetic library.
- Uses one N-bit row adder over multiple cycles, one partial-product row per cycle, instead of a full combinational array.
- Horizontal cut (H) and vertical cut (V) are sampled per operation, so one instance can sweep approximation levels during error/energy characterisation.
- Has a valid/ready request side and a valid/ready result side, for use in evaluation harnesses and accelerator lanes.

---
 rtl/bam_pkg.sv | 39 +++
 rtl/bam_row_mask.sv | 19 +
 rtl/bam_seq_mul_ctrl.sv | 111 +++++++++++
 tb/tb_bam_seq_mul_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bam_pkg.sv
// Shared types and helpers for the sequential broken-array multiplier.
// Holds the FSM state type, width helpers and the golden model.
package bam_pkg;

  localparam int N_DEF = 8;
  localparam int P_DEF = 2 * N_DEF;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  function automatic int hw_of(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int vw_of(input int n);
    return $clog2(2 * n);
  endfunction

  function automatic logic [P_DEF-1:0] bam_ref(
    input logic [N_DEF-1:0] a,
    input logic [N_DEF-1:0] b,
    input int h,
    input int v
  );
    logic [P_DEF-1:0] p;
    p = '0;
    for (int j = 0; j < N_DEF; j++) begin
      for (int i = 0; i < N_DEF; i++) begin
        if (a[i] && b[j] && j >= h && i + j >= v)
          p = p + (P_DEF'(1) << (i + j));
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/bam_row_mask.sv
// Keep mask for one partial-product row under a vertical cut.
// Bit i survives when its column i+row is at or beyond the cut.
module bam_row_mask import bam_pkg::*; #(
  parameter int N  = 8,
  parameter int RW = hw_of(N),
  parameter int VW = vw_of(N)
) (
  input  logic [RW-1:0] row,
  input  logic [VW-1:0] v,
  output logic [N-1:0]  mask
);

  always_comb begin
    mask = '0;
    for (int i = 0; i < N; i++)
      mask[i] = (i + int'(row)) >= int'(v);
  end

endmodule

// File: rtl/bam_seq_mul_ctrl.sv
// Sequential broken-array multiplier, one partial-product row per cycle.
// Cuts are captured at acceptance so one instance can sweep approximation levels.
module bam_seq_mul_ctrl import bam_pkg::*; #(
  parameter int N  = 8,
  parameter int HW = hw_of(N),
  parameter int VW = vw_of(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_a,
  input  logic [N-1:0]  in_b,
  input  logic [HW-1:0] cfg_h,
  input  logic [VW-1:0] cfg_v,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [2*N-1:0] out_p,
  output logic          busy
);

  localparam int PW = 2 * N;
  localparam logic [HW-1:0] LAST = HW'(N - 1);
  localparam logic [HW-1:0] NROW = HW'(N);

  state_t state_q, state_d;

  logic [N-1:0]  a_q, b_q;
  logic [HW-1:0] row_q;
  logic [VW-1:0] v_q;
  logic [PW-1:0] acc_q, p_q;

  logic [N-1:0]  mask, b_sh;
  logic [PW-1:0] term, acc_nxt;
  logic          last;

  bam_row_mask #(
    .N  (N),
    .RW (HW),
    .VW (VW)
  ) u_mask (
    .row  (row_q),
    .v    (v_q),
    .mask (mask)
  );

  always_comb begin
    b_sh    = b_q >> row_q;
    term    = b_sh[0] ? (PW'(a_q & mask) << row_q) : '0;
    acc_nxt = acc_q + term;
    last    = row_q == LAST;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid)
          state_d = (cfg_h < NROW) ? RUN : DONE;
      end
      RUN: begin
        busy = 1'b1;
        if (last)
          state_d = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      row_q   <= '0;
      v_q     <= '0;
      acc_q   <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && in_valid) begin
        a_q   <= in_a;
        b_q   <= in_b;
        row_q <= cfg_h;
        v_q   <= cfg_v;
        acc_q <= '0;
        if (cfg_h >= NROW)
          p_q <= '0;
      end else if (state_q == RUN) begin
        acc_q <= acc_nxt;
        row_q <= row_q + HW'(1);
        // Result register is separate so it survives the return to IDLE.
        if (last)
          p_q <= acc_nxt;
      end
    end
  end

  assign out_p = p_q;

endmodule

// File: tb/tb_bam_seq_mul_ctrl.sv
// Self-checking bench for bam_seq_mul_ctrl.
// Directed scenarios plus a randomized sweep against a bit-sum model.
module tb_bam_seq_mul_ctrl;

  logic        clk = 0;
  logic        rst = 1;
  logic        in_valid = 0;
  logic        in_ready;
  logic [7:0]  in_a = 0;
  logic [7:0]  in_b = 0;
  logic [3:0]  cfg_h = 0;
  logic [3:0]  cfg_v = 0;
  logic        out_valid;
  logic        out_ready = 0;
  logic [15:0] out_p;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  bam_seq_mul_ctrl #(.N(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .cfg_h     (cfg_h),
    .cfg_v     (cfg_v),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic int model_p(input int a, input int b, input int h, input int v);
    int p;
    p = 0;
    for (int j = 0; j < 8; j++)
      for (int i = 0; i < 8; i++)
        if (j >= h && i + j >= v)
          p += (((a >> i) & 1) * ((b >> j) & 1)) << (i + j);
    return p;
  endfunction

  function automatic int model_lat(input int h);
    return (h >= 8 ? 0 : 8 - h) + 1;
  endfunction

  task automatic drive(input int a, input int b, input int h, input int v);
    in_a     = 8'(a);
    in_b     = 8'(b);
    cfg_h    = 4'(h);
    cfg_v    = 4'(v);
    in_valid = 1'b1;
  endtask

  // Counts edges starting with the accepting one; scrambles inputs afterwards.
  task automatic wait_valid(output int edges, output bit expired);
    edges   = 0;
    expired = 0;
    do begin
      @(posedge clk);
      #1;
      edges++;
      if (edges == 1) begin
        in_valid = 1'b0;
        in_a     = 8'($urandom);
        in_b     = 8'($urandom);
        cfg_h    = 4'($urandom);
        cfg_v    = 4'($urandom);
      end
    end while (!out_valid && edges < 40);
    expired = !out_valid;
  endtask

  task automatic handoff();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic run_op(input string name, input int a, input int b,
                        input int h, input int v);
    int edges;
    bit expired;
    int exp_p;
    exp_p = model_p(a, b, h, v);
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s in_ready before request: got %0b want 1", name, in_ready);
    end
    drive(a, b, h, v);
    wait_valid(edges, expired);
    vectors++;
    if (expired) begin
      miscompares++;
      $display("FAIL %s timeout: out_valid never rose", name);
    end
    vectors++;
    if (edges != model_lat(h)) begin
      miscompares++;
      $display("FAIL %s latency: got %0d want %0d", name, edges, model_lat(h));
    end
    vectors++;
    if (out_p !== 16'(exp_p)) begin
      miscompares++;
      $display("FAIL %s out_p: got %0d want %0d", name, out_p, exp_p);
    end
    handoff();
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s after handoff: valid=%0b ready=%0b busy=%0b want 0 1 0",
               name, out_valid, in_ready, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_p !== 16'd0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: ready=%0b valid=%0b p=%0d busy=%0b want 1 0 0 0",
               in_ready, out_valid, out_p, busy);
    end
    rst = 1'b0;
  endtask

  task automatic test_exact();
    run_op("exact", 255, 255, 0, 0);
    run_op("exact_small", 3, 5, 0, 0);
  endtask

  task automatic test_cut();
    run_op("cut_h1_v9", 255, 255, 1, 9);
  endtask

  task automatic test_degenerate();
    run_op("degen_h8", 200, 77, 8, 0);
    run_op("degen_v15", 200, 77, 0, 15);
  endtask

  task automatic test_backpressure();
    int edges;
    bit expired;
    drive(13, 11, 0, 0);
    wait_valid(edges, expired);
    vectors++;
    if (expired || out_p !== 16'd143) begin
      miscompares++;
      $display("FAIL bp_first: got %0d want 143 (expired=%0b)", out_p, expired);
    end
    drive(7, 9, 0, 0);
    repeat (5) begin
      @(posedge clk);
      #1;
      vectors++;
      if (out_valid !== 1'b1 || out_p !== 16'd143 || in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_hold: valid=%0b p=%0d ready=%0b want 1 143 0",
                 out_valid, out_p, in_ready);
      end
    end
    handoff();
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_p !== 16'd143) begin
      miscompares++;
      $display("FAIL bp_release: valid=%0b ready=%0b p=%0d want 0 1 143",
               out_valid, in_ready, out_p);
    end
    wait_valid(edges, expired);
    vectors++;
    if (expired || edges != 9 || out_p !== 16'd63) begin
      miscompares++;
      $display("FAIL bp_pending: p=%0d lat=%0d got, want 63 lat 9", out_p, edges);
    end
    handoff();
  endtask

  task automatic test_reset_mid_run();
    drive(255, 255, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_p !== 16'd0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset: ready=%0b valid=%0b p=%0d busy=%0b want 1 0 0 0",
               in_ready, out_valid, out_p, busy);
    end
    run_op("after_reset", 3, 5, 0, 0);
  endtask

  task automatic test_random();
    int a, b, h, v, k, exp_p, edges;
    bit expired;
    for (int n = 0; n < 2000; n++) begin
      a = int'($urandom_range(0, 255));
      b = int'($urandom_range(0, 255));
      h = int'($urandom_range(0, 8));
      v = int'($urandom_range(0, 15));
      exp_p = model_p(a, b, h, v);
      drive(a, b, h, v);
      wait_valid(edges, expired);
      vectors++;
      if (expired || out_p !== 16'(exp_p) || edges != model_lat(h)) begin
        miscompares++;
        $display("FAIL rand a=%0d b=%0d h=%0d v=%0d: p=%0d lat=%0d want %0d lat %0d",
                 a, b, h, v, out_p, edges, exp_p, model_lat(h));
      end
      k = int'($urandom_range(0, 3));
      for (int c = 0; c < k; c++) begin
        @(posedge clk);
        #1;
        vectors++;
        if (out_valid !== 1'b1 || out_p !== 16'(exp_p)) begin
          miscompares++;
          $display("FAIL rand_hold: valid=%0b p=%0d want 1 %0d", out_valid, out_p, exp_p);
        end
      end
      handoff();
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL rand_handoff: valid=%0b ready=%0b want 0 1", out_valid, in_ready);
      end
    end
  endtask

  initial begin
    test_reset();
    test_exact();
    test_cut();
    test_degenerate();
    test_backpressure();
    test_reset_mid_run();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
